// File: rtl/xnor_serial_cmp_arb.sv
// xnor_serial_cmp_arb: bit-serial word-equality engine sharing one XNOR between two requesters
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   req0_valid/ready/a/b            requester 0 operand handshake
//   req1_valid/ready/a/b            requester 1 operand handshake
//   res_valid/ready                 result handshake
//   res_id                          requester that owns the result
//   res_equal                       1 when the operands are identical
//   res_match_cnt                   matching bit positions (CW bits)
//   busy                            high while an operation is in RUN or DONE
//
// Optional feature: define XNOR_EARLY_EXIT_EN to stop at the first mismatching
// bit; res_match_cnt then reports the index of that first mismatch.
module xnor_serial_cmp_arb #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic             res_equal,
    output logic [CW-1:0]    res_match_cnt,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             owner;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CW-1:0]    idx;
    logic [CW-1:0]    cnt;
    logic             grant_any;
    logic             grant_id;
    logic             bit_eq;
    logic             run_end;

    assign grant_any = req0_valid | req1_valid;
    // On contention the requester that did not win last time gets the grant.
    assign grant_id  = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    assign bit_eq    = ~(sa[0] ^ sb[0]);

`ifdef XNOR_EARLY_EXIT_EN
    assign run_end = (idx == CW'(WIDTH - 1)) | ~bit_eq;
`else
    assign run_end = idx == CW'(WIDTH - 1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = grant_any ? RUN : IDLE;
            RUN:     state_nxt = run_end ? DONE : RUN;
            DONE:    state_nxt = (res_valid & res_ready) ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready is gated by rst so nothing is accepted while reset is held.
    always_comb begin
        busy       = state != IDLE;
        req0_ready = ~rst & (state == IDLE) & req0_valid & ~grant_id;
        req1_ready = ~rst & (state == IDLE) & req1_valid & grant_id;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant    <= 1'b1;
            owner         <= 1'b0;
            sa            <= '0;
            sb            <= '0;
            idx           <= '0;
            cnt           <= '0;
            res_valid     <= 1'b0;
            res_id        <= 1'b0;
            res_equal     <= 1'b0;
            res_match_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        sa    <= grant_id ? req1_a : req0_a;
                        sb    <= grant_id ? req1_b : req0_b;
                        cnt   <= '0;
                        idx   <= '0;
                        owner <= grant_id;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    idx <= idx + CW'(1);
                    cnt <= cnt + CW'(bit_eq);
                end
                DONE: begin
                    // First DONE cycle registers the result; it then holds until taken.
                    if (!res_valid) begin
                        res_valid     <= 1'b1;
                        res_id        <= owner;
                        res_match_cnt <= cnt;
                        res_equal     <= cnt == CW'(WIDTH);
                    end else if (res_ready) begin
                        res_valid  <= 1'b0;
                        last_grant <= owner;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_xnor_serial_cmp_arb.sv
// tb_xnor_serial_cmp_arb: randomized and directed checks against a transaction-level model
module tb_xnor_serial_cmp_arb;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b0;
    logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          req0_ready, req1_ready, res_valid, res_id, res_equal, busy;
    logic [CW-1:0] res_match_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    xnor_serial_cmp_arb #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_equal(res_equal), .res_match_cnt(res_match_cnt), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected result and RUN length of one comparison, straight from the rules.
    function automatic void calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output int cnt, output bit eq, output int runlen);
        bit found;
        found  = 0;
        cnt    = 0;
        runlen = W;
        eq     = (a == b);
`ifdef XNOR_EARLY_EXIT_EN
        for (int i = 0; i < W; i++)
            if (!found && a[i] != b[i]) begin
                found  = 1;
                cnt    = i;
                runlen = i + 1;
            end
        if (!found) cnt = W;
`else
        for (int i = 0; i < W; i++) cnt += (a[i] == b[i]) ? 1 : 0;
`endif
    endfunction

    // Transaction model: an accepted job becomes visible runlen+1 edges after acceptance.
    bit m_busy = 0, m_valid = 0, m_owner = 0, m_last = 1, m_eq = 0;
    int m_cnt = 0, m_wait = 0;

    always @(negedge clk) begin
        bit g_any, g_id, e0, e1;
        int rl;
        if (rst) begin
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_valid", res_valid, 0);
            chk("rst_id", res_id, 0);
            chk("rst_equal", res_equal, 0);
            chk("rst_cnt", res_match_cnt, 0);
            m_busy = 0; m_valid = 0; m_last = 1;
        end else begin
            g_any = req0_valid | req1_valid;
            g_id  = (req0_valid && req1_valid) ? !m_last : req1_valid;
            e0    = !m_busy && req0_valid && !g_id;
            e1    = !m_busy && req1_valid && g_id;
            chk("ready0", req0_ready, e0);
            chk("ready1", req1_ready, e1);
            chk("busy", busy, m_busy);
            chk("res_valid", res_valid, m_valid);
            if (m_valid) begin
                chk("res_id", res_id, m_owner);
                chk("res_equal", res_equal, m_eq);
                chk("res_cnt", res_match_cnt, m_cnt);
            end
            if (!m_busy) begin
                if (g_any) begin
                    m_busy  = 1;
                    m_owner = g_id;
                    calc(g_id ? req1_a : req0_a, g_id ? req1_b : req0_b, m_cnt, m_eq, rl);
                    m_wait  = rl + 1;
                end
            end else if (!m_valid) begin
                m_wait--;
                if (m_wait == 0) m_valid = 1;
            end else if (res_ready) begin
                m_valid = 0;
                m_busy  = 0;
                m_last  = m_owner;
            end
        end
    end

    task automatic drive(input bit id, input bit v, input logic [W-1:0] a, input logic [W-1:0] b);
        if (id) begin req1_valid = v; req1_a = a; req1_b = b; end
        else    begin req0_valid = v; req0_a = a; req0_b = b; end
    endtask

    task automatic run_one(input string tag, input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int exp_cnt, input bit exp_eq, input int exp_lat);
        int n, t0;
        @(posedge clk); #2;
        res_ready = 1;
        drive(id, 1, a, b);
        n = 0;
        do begin @(negedge clk); n++; end while (!(id ? req1_ready : req0_ready) && n < 40);
        chk({tag, "_grant"}, id ? req1_ready : req0_ready, 1);
        @(posedge clk); #2;
        t0 = cyc;
        drive(id, 0, a, b);
        n = 0;
        do begin @(negedge clk); n++; end while (!res_valid && n < 40);
        chk({tag, "_valid"}, res_valid, 1);
        chk({tag, "_lat"}, cyc - t0, exp_lat);
        chk({tag, "_id"}, res_id, id);
        chk({tag, "_eq"}, res_equal, exp_eq);
        chk({tag, "_cnt"}, res_match_cnt, exp_cnt);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1;
        repeat (2) @(posedge clk);
        #2 rst = 0;
    endtask

    function automatic logic [W-1:0] rnd_b(input logic [W-1:0] a);
        int k;
        k = int'($urandom_range(0, W - 1));
        case ($urandom_range(0, 2))
            0:       return a;
            1:       return a ^ (W'(1) << k);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g[4];
        int ng, n, seen;
        bit r0, r1;
        logic [W-1:0] ta;

        // Asynchronous reset before any clock edge.
        #1 rst = 1;
        #1;
        chk("async_valid", res_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_cnt", res_match_cnt, 0);
        repeat (2) @(posedge clk);
        #2 rst = 0;

        run_one("eq_a5", 0, 8'hA5, 8'hA5, 8, 1, 9);
        run_one("ne_0f", 1, 8'h0F, 8'h8F, 7, 0, 9);
`ifdef XNOR_EARLY_EXIT_EN
        run_one("ne_f0", 0, 8'hF0, 8'h0F, 0, 0, 2);
`else
        run_one("ne_f0", 0, 8'hF0, 8'h0F, 0, 0, 9);
`endif

        // Continuous contention from reset: grants alternate starting with 0.
        do_reset();
        res_ready = 1;
        drive(0, 1, 8'h11, 8'h11);
        drive(1, 1, 8'h22, 8'h23);
        ng = 0; n = 0;
        while (ng < 4 && n < 200) begin
            @(negedge clk); n++;
            if (req0_ready || req1_ready) begin g[ng] = req1_ready ? 1 : 0; ng++; end
        end
        chk("rr_count", ng, 4);
        for (int i = 0; i < 4; i++) chk("rr_order", g[i], i % 2);
        @(posedge clk); #2;
        drive(0, 0, 8'h11, 8'h11);
        drive(1, 0, 8'h22, 8'h23);
        repeat (14) @(posedge clk);

        // Stall in DONE with req1 pending.
        #2 res_ready = 0;
        drive(0, 1, 8'h3C, 8'h3D);
        n = 0;
        do begin @(negedge clk); n++; end while (!req0_ready && n < 40);
        @(posedge clk); #2;
        drive(0, 0, 8'h3C, 8'h3D);
        drive(1, 1, 8'h55, 8'h55);
        n = 0;
        do begin @(negedge clk); n++; end while (!res_valid && n < 40);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_valid", res_valid, 1);
            chk("stall_id", res_id, 0);
            chk("stall_eq", res_equal, 0);
`ifdef XNOR_EARLY_EXIT_EN
            chk("stall_cnt", res_match_cnt, 0);
`else
            chk("stall_cnt", res_match_cnt, 7);
`endif
            chk("stall_ready1", req1_ready, 0);
            chk("stall_busy", busy, 1);
        end
        @(posedge clk); #2 res_ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("after_stall_ready1", req1_ready, 1);
        @(posedge clk); #2;
        drive(1, 0, 8'h55, 8'h55);
        n = 0;
        do begin @(negedge clk); n++; end while (!res_valid && n < 40);
        chk("after_stall_id", res_id, 1);
        chk("after_stall_cnt", res_match_cnt, 8);
        chk("after_stall_eq", res_equal, 1);

        // Reset in the middle of RUN.
        @(posedge clk); #2;
        drive(0, 1, 8'h12, 8'h34);
        n = 0;
        do begin @(negedge clk); n++; end while (!req0_ready && n < 40);
        @(posedge clk); #2;
        drive(0, 0, 8'h12, 8'h34);
        repeat (3) @(posedge clk);
        #2 rst = 1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", res_valid, 0);
        repeat (2) @(posedge clk);
        #2 rst = 0;
        seen = 0;
        repeat (12) begin @(negedge clk); seen |= res_valid; end
        chk("midrst_no_result", seen, 0);
        run_one("post_rst", 0, 8'h81, 8'h81, 8, 1, 9);

        // Randomized traffic.
        for (int c = 0; c < 900; c++) begin
            @(negedge clk);
            r0 = req0_ready;
            r1 = req1_ready;
            @(posedge clk); #2;
            res_ready = ($urandom_range(0, 3) != 0);
            if (r0 || (!req0_valid && $urandom_range(0, 2) == 0)) begin
                ta = W'($urandom);
                drive(0, r0 ? ($urandom_range(0, 2) != 0) : 1'b1, ta, rnd_b(ta));
            end else if (req0_valid && $urandom_range(0, 19) == 0) req0_valid = 0;
            if (r1 || (!req1_valid && $urandom_range(0, 2) == 0)) begin
                ta = W'($urandom);
                drive(1, r1 ? ($urandom_range(0, 2) != 0) : 1'b1, ta, rnd_b(ta));
            end else if (req1_valid && $urandom_range(0, 19) == 0) req1_valid = 0;
        end
        req0_valid = 0;
        req1_valid = 0;
        res_ready  = 1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
